// File: rtl/sev_seg_mux_if.sv
// Display-side signal bundle for sev_seg_mux: snapshot inputs in, active-low pin drives out.
// The master modport belongs to the producer of digit data; the slave modport belongs to the driver.
interface sev_seg_mux_if #(
  parameter int unsigned NUM_DIGITS = 2
);
  logic [4*NUM_DIGITS-1:0] digits_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   blank_in;
  logic                    lz_en;
  logic [6:0]              seg;
  logic                    dp_n;
  logic [NUM_DIGITS-1:0]   an_n;
  logic                    frame_start;

  modport master (
    output digits_in,
    output dp_in,
    output blank_in,
    output lz_en,
    input  seg,
    input  dp_n,
    input  an_n,
    input  frame_start
  );

  modport slave (
    input  digits_in,
    input  dp_in,
    input  blank_in,
    input  lz_en,
    output seg,
    output dp_n,
    output an_n,
    output frame_start
  );
endinterface

// File: rtl/sev_seg_mux.sv
// Time-multiplexed common-anode seven-segment driver with per-frame input snapshot,
// blanking, leading-zero suppression, decimal points and an anti-ghosting guard interval.
module sev_seg_mux #(
  parameter int unsigned NUM_DIGITS  = 2,
  parameter int unsigned REFRESH_DIV = 20000,
  parameter int unsigned GUARD_CYC   = 1000
) (
  input  logic         clk,
  input  logic         reset,
  sev_seg_mux_if.slave io_disp
);

  localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(REFRESH_DIV - 1);
  localparam logic [IdxW-1:0] IdxMax = IdxW'(NUM_DIGITS - 1);

  logic [CntW-1:0]         r_cnt;
  logic [IdxW-1:0]         r_idx;
  logic [4*NUM_DIGITS-1:0] r_snap_digits;
  logic [NUM_DIGITS-1:0]   r_snap_dp;
  logic [NUM_DIGITS-1:0]   r_snap_blank;
  logic                    r_snap_lz;
  logic [NUM_DIGITS-1:0]   r_an_n;
  logic [6:0]              r_seg;
  logic                    r_dp_n;
  logic                    r_frame_start;

  logic                    w_take;
  logic                    w_cnt_wrap;
  logic                    w_idx_wrap;
  logic                    w_guard;
  logic [4*NUM_DIGITS-1:0] w_src_digits;
  logic [NUM_DIGITS-1:0]   w_src_dp;
  logic [NUM_DIGITS-1:0]   w_src_blank;
  logic                    w_src_lz;
  logic [3:0]              w_nib;
  logic                    w_dp_req;
  logic                    w_blank;
  logic                    w_suppress;
  logic                    w_zero_run;
  logic [NUM_DIGITS-1:0]   w_an_n_d;
  logic [6:0]              w_seg_d;
  logic                    w_dp_n_d;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    unique case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0011000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign w_take     = (r_cnt == '0) && (r_idx == '0);
  assign w_cnt_wrap = (r_cnt == CntMax);
  assign w_idx_wrap = (r_idx == IdxMax);

  if (GUARD_CYC == 0) begin : g_no_guard
    assign w_guard = 1'b0;
  end else begin : g_guard
    assign w_guard = (32'(r_cnt) < GUARD_CYC);
  end

  // On the snapshot edge the incoming values are used directly so the whole frame,
  // including its very first displayed cycle, comes from one consistent snapshot.
  assign w_src_digits = w_take ? io_disp.digits_in : r_snap_digits;
  assign w_src_dp     = w_take ? io_disp.dp_in     : r_snap_dp;
  assign w_src_blank  = w_take ? io_disp.blank_in  : r_snap_blank;
  assign w_src_lz     = w_take ? io_disp.lz_en     : r_snap_lz;

  // Walk from the most significant digit down; w_zero_run stays high while all nibbles seen are 0.
  always_comb begin
    w_nib      = '0;
    w_dp_req   = 1'b0;
    w_blank    = 1'b0;
    w_suppress = 1'b0;
    w_zero_run = 1'b1;
    for (int k = int'(NUM_DIGITS) - 1; k >= 0; k--) begin
      w_zero_run = w_zero_run & (w_src_digits[4*k +: 4] == 4'h0);
      if (r_idx == IdxW'(k)) begin
        w_nib      = w_src_digits[4*k +: 4];
        w_dp_req   = w_src_dp[k];
        w_blank    = w_src_blank[k];
        w_suppress = w_src_lz && (k != 0) && w_zero_run;
      end
    end
  end

  always_comb begin
    w_an_n_d = '1;
    w_seg_d  = 7'b1111111;
    w_dp_n_d = 1'b1;
    if (!w_guard) begin
      for (int k = 0; k < int'(NUM_DIGITS); k++) begin
        if (r_idx == IdxW'(k)) begin
          w_an_n_d[k] = 1'b0;
        end
      end
      if (!w_blank) begin
        w_dp_n_d = ~w_dp_req;
        if (!w_suppress) begin
          w_seg_d = hex_to_seg(w_nib);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (w_cnt_wrap) begin
      r_cnt <= '0;
      r_idx <= w_idx_wrap ? '0 : r_idx + IdxW'(1);
    end else begin
      r_cnt <= r_cnt + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_snap_digits <= '0;
      r_snap_dp     <= '0;
      r_snap_blank  <= '0;
      r_snap_lz     <= 1'b0;
    end else if (w_take) begin
      r_snap_digits <= io_disp.digits_in;
      r_snap_dp     <= io_disp.dp_in;
      r_snap_blank  <= io_disp.blank_in;
      r_snap_lz     <= io_disp.lz_en;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_an_n        <= '1;
      r_seg         <= 7'b1111111;
      r_dp_n        <= 1'b1;
      r_frame_start <= 1'b0;
    end else begin
      r_an_n        <= w_an_n_d;
      r_seg         <= w_seg_d;
      r_dp_n        <= w_dp_n_d;
      r_frame_start <= w_take;
    end
  end

  assign io_disp.an_n        = r_an_n;
  assign io_disp.seg         = r_seg;
  assign io_disp.dp_n        = r_dp_n;
  assign io_disp.frame_start = r_frame_start;

endmodule

// File: tb/tb_sev_seg_mux.sv
// Bench for sev_seg_mux: a 4-digit instance and a 1-digit/no-guard instance, both checked each
// cycle against a cycle-count model of the scan schedule and per-frame input snapshots.
module tb_sev_seg_mux;

  localparam int NA = 4, RDA = 8, GA = 2;
  localparam int NB = 1, RDB = 2, GB = 0;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dpn;
    logic       fs;
  } exp_t;

  localparam exp_t Dark = '{an: 4'hf, seg: 7'h7f, dpn: 1'b1, fs: 1'b0};

  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   checks = 0;
  int   failures = 0;

  // Model state: edges since reset release, plus the snapshot the model believes is current.
  int          e_a, e_b;
  logic [15:0] sd_a, sd_b;
  logic [3:0]  sdp_a, sbl_a, sdp_b, sbl_b;
  logic        slz_a, slz_b;

  always #5 clk = ~clk;

  sev_seg_mux_if #(.NUM_DIGITS(NA)) if_a ();
  sev_seg_mux_if #(.NUM_DIGITS(NB)) if_b ();

  sev_seg_mux #(.NUM_DIGITS(NA), .REFRESH_DIV(RDA), .GUARD_CYC(GA)) u_dut_a (
    .clk    (clk),
    .reset  (rst_a),
    .io_disp(if_a)
  );

  sev_seg_mux #(.NUM_DIGITS(NB), .REFRESH_DIV(RDB), .GUARD_CYC(GB)) u_dut_b (
    .clk    (clk),
    .reset  (rst_b),
    .io_disp(if_b)
  );

  // Output after edge e reflects slot e%rd of digit (e/rd)%n, from the frame snapshot.
  function automatic exp_t model(int n, int rd, int g, int e, logic [15:0] d,
                                 logic [3:0] dp, logic [3:0] bl, logic lz);
    exp_t        r;
    int          k;
    logic [15:0] upper;
    r    = Dark;
    r.fs = ((e % (rd * n)) == 0);
    k    = (e / rd) % n;
    if ((e % rd) >= g) begin
      r.an[k] = 1'b0;
      upper   = d >> (4 * k);
      if (!bl[k]) begin
        r.dpn = ~dp[k];
        if (!(lz && k != 0 && upper == 16'h0)) r.seg = seg_tab[upper[3:0]];
      end
    end
    return r;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step();
    exp_t xa, xb;
    @(posedge clk);
    if (rst_a) begin
      xa  = Dark;
      e_a = 0;
    end else begin
      if (e_a % (RDA * NA) == 0) begin
        sd_a  = if_a.digits_in;
        sdp_a = if_a.dp_in;
        sbl_a = if_a.blank_in;
        slz_a = if_a.lz_en;
      end
      xa = model(NA, RDA, GA, e_a, sd_a, sdp_a, sbl_a, slz_a);
      e_a++;
    end
    if (rst_b) begin
      xb  = Dark;
      e_b = 0;
    end else begin
      if (e_b % (RDB * NB) == 0) begin
        sd_b  = {12'h0, if_b.digits_in};
        sdp_b = {3'b0, if_b.dp_in};
        sbl_b = {3'b0, if_b.blank_in};
        slz_b = if_b.lz_en;
      end
      xb = model(NB, RDB, GB, e_b, sd_b, sdp_b, sbl_b, slz_b);
      e_b++;
    end
    @(negedge clk);
    chk("a_an_n", 32'(if_a.an_n), 32'(xa.an));
    chk("a_seg", 32'(if_a.seg), 32'(xa.seg));
    chk("a_dp_n", 32'(if_a.dp_n), 32'(xa.dpn));
    chk("a_frame_start", 32'(if_a.frame_start), 32'(xa.fs));
    chk("a_anode_onehot0", 32'($countones(~if_a.an_n) <= 1), 32'd1);
    chk("b_an_n", 32'(if_b.an_n), 32'(xb.an[0]));
    chk("b_seg", 32'(if_b.seg), 32'(xb.seg));
    chk("b_dp_n", 32'(if_b.dp_n), 32'(xb.dpn));
    chk("b_frame_start", 32'(if_b.frame_start), 32'(xb.fs));
  endtask

  task automatic rand_a();
    if_a.digits_in = 16'($urandom);
    if_a.dp_in     = 4'($urandom);
    if_a.blank_in  = 4'($urandom_range(0, 3) == 0 ? $urandom : 0);
    if_a.lz_en     = 1'($urandom);
    if ($urandom_range(0, 2) == 0) if_a.digits_in[15:8] = 8'h00;
  endtask

  initial begin
    e_a = 0; e_b = 0;
    sd_a = '0; sdp_a = '0; sbl_a = '0; slz_a = 1'b0;
    sd_b = '0; sdp_b = '0; sbl_b = '0; slz_b = 1'b0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    if_a.digits_in = 16'h4B7E; if_a.dp_in = 4'b0000; if_a.blank_in = 4'b0000; if_a.lz_en = 1'b0;
    if_b.digits_in = 4'h0;     if_b.dp_in = 1'b0;    if_b.blank_in = 1'b0;    if_b.lz_en = 1'b0;

    // Held reset: everything dark.
    repeat (3) step();
    rst_a = 1'b0;
    rst_b = 1'b0;

    // Plain scan of 4B7E across more than one frame.
    repeat (40) step();

    // Leading-zero suppression with a dp on a suppressed digit, then all zeros.
    if_a.digits_in = 16'h0050; if_a.lz_en = 1'b1; if_a.dp_in = 4'b1000;
    repeat (32) step();
    if_a.digits_in = 16'h0000;
    repeat (32) step();

    // Blank digit 1 while its dp is requested.
    if_a.digits_in = 16'h1234; if_a.lz_en = 1'b0; if_a.blank_in = 4'b0010; if_a.dp_in = 4'b0010;
    repeat (32) step();

    // Mid-frame input churn on both instances.
    if_a.blank_in = 4'b0000;
    repeat (12) begin
      if_a.digits_in = 16'($urandom);
      if_b.digits_in = 4'($urandom);
      repeat (5) step();
    end

    // Every decode value through the 1-digit instance, each held across one snapshot.
    for (int v = 0; v < 16; v++) begin
      if_b.digits_in = 4'(v);
      if_b.dp_in     = 1'($urandom);
      if_b.blank_in  = 1'b0;
      if_b.lz_en     = 1'($urandom);
      repeat (2) step();
    end
    if_b.blank_in = 1'b1;
    repeat (4) step();
    if_b.blank_in = 1'b0;

    // Randomized traffic.
    repeat (50) begin
      rand_a();
      if_b.digits_in = 4'($urandom);
      if_b.dp_in     = 1'($urandom);
      if_b.blank_in  = 1'($urandom_range(0, 3) == 0);
      if_b.lz_en     = 1'($urandom);
      repeat ($urandom_range(1, 12)) step();
    end

    // Reset during the ON phase of digit 2, then a fresh frame.
    for (int i = 0; i < 64 && (e_a % (RDA * NA)) != (2 * RDA + GA + 2); i++) step();
    rst_a = 1'b1;
    repeat (2) step();
    rand_a();
    rst_a = 1'b0;
    repeat (40) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
